// File: rtl/decode_stage_hz_pkg.sv
// Shared decode constants for decode_stage_hz: opcodes, ALU/result/immediate
// selector encodings, the control bundle and immediate extraction.
package decode_stage_hz_pkg;

   localparam int unsigned WORD_SIZE = 32;

   typedef enum logic [6:0] {
      OP_R    = 7'b0110011,
      OP_IALU = 7'b0010011,
      OP_LW   = 7'b0000011,
      OP_SW   = 7'b0100011,
      OP_BEQ  = 7'b1100011,
      OP_JAL  = 7'b1101111
   } opcode_e;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_SLT = 3'b101
   } alu_ctrl_e;

   typedef enum logic [1:0] {
      RES_ALU = 2'b00,
      RES_MEM = 2'b01,
      RES_PC4 = 2'b10
   } result_src_e;

   typedef enum logic [2:0] {
      IMM_NONE = 3'd0,
      IMM_I    = 3'd1,
      IMM_S    = 3'd2,
      IMM_B    = 3'd3,
      IMM_J    = 3'd4
   } imm_src_e;

   typedef struct packed {
      logic        regWrite;
      logic        memWrite;
      logic        jump;
      logic        branch;
      logic        aluSrc;
      result_src_e resultSrc;
      alu_ctrl_e   aluControl;
   } ctrl_t;

   function automatic logic [31:0] immExt32(input logic [31:0] instr, input imm_src_e src);
      case (src)
         IMM_I:   return {{20{instr[31]}}, instr[31:20]};
         IMM_S:   return {{20{instr[31]}}, instr[31:25], instr[11:7]};
         IMM_B:   return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         IMM_J:   return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         default: return '0;
      endcase
   endfunction

endpackage

// File: rtl/decode_stage_hz_reg_file_bp.sv
// Register file with two read ports and one write port; x0 reads zero.
// BYPASS_WB selects posedge write with same-cycle forwarding, or negedge write.
module reg_file_bp
   import decode_stage_hz_pkg::*;
#(
   parameter int unsigned NREGS     = 32,
   parameter int unsigned XLEN      = WORD_SIZE,
   parameter bit          BYPASS_WB = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [4:0]      a1,
   input  logic [4:0]      a2,
   output logic [XLEN-1:0] rd1,
   output logic [XLEN-1:0] rd2,
   input  logic            we,
   input  logic [4:0]      wa,
   input  logic [XLEN-1:0] wd
);
   localparam int unsigned AW = $clog2(NREGS);

   logic [XLEN-1:0] regs [NREGS];
   logic            wrEn;

   assign wrEn = we && (wa != '0) && (32'(wa) < NREGS);

   if (BYPASS_WB) begin : gPosWrite
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
         end else if (wrEn) begin
            regs[wa[AW-1:0]] <= wd;
         end
      end
   end else begin : gNegWrite
      // Half-cycle-early write makes the value visible at the next posedge without a mux
      always_ff @(negedge clk or negedge rst) begin
         if (!rst) begin
            for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
         end else if (wrEn) begin
            regs[wa[AW-1:0]] <= wd;
         end
      end
   end

   always_comb begin
      rd1 = '0;
      rd2 = '0;
      if (a1 != '0 && 32'(a1) < NREGS) begin
         rd1 = regs[a1[AW-1:0]];
         if (BYPASS_WB && we && wa == a1) rd1 = wd;
      end
      if (a2 != '0 && 32'(a2) < NREGS) begin
         rd2 = regs[a2[AW-1:0]];
         if (BYPASS_WB && we && wa == a2) rd2 = wd;
      end
   end

endmodule

// File: rtl/decode_stage_hz.sv
// RV32I decode stage: decoder, register file, load-use hazard detection and
// the ID/EX register with flush/stall/bubble/illegal handling.
module decode_stage_hz
   import decode_stage_hz_pkg::*;
#(
   parameter int unsigned XLEN      = WORD_SIZE,
   parameter int unsigned NREGS     = 32,
   parameter bit          BYPASS_WB = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [31:0]     InstrD,
   input  logic [XLEN-1:0] PCD,
   input  logic [XLEN-1:0] PCPlus4D,
   input  logic            StallE,
   input  logic            FlushE,
   input  logic            RegWriteW,
   input  logic [4:0]      RdW,
   input  logic [XLEN-1:0] ResultW,
   output logic            StallD,
   output logic [XLEN-1:0] RD1E,
   output logic [XLEN-1:0] RD2E,
   output logic [XLEN-1:0] PCE,
   output logic [XLEN-1:0] PCPlus4E,
   output logic [4:0]      Rs1E,
   output logic [4:0]      Rs2E,
   output logic [4:0]      RdE,
   output logic [XLEN-1:0] ImmExtE,
   output logic            RegWriteE,
   output logic            MemWriteE,
   output logic            JumpE,
   output logic            BranchE,
   output logic            ALUSrcE,
   output logic [1:0]      ResultSrcE,
   output logic [2:0]      ALUControlE,
   output logic            IllegalE
);
   logic [6:0]      opcode, funct7;
   logic [2:0]      funct3;
   logic [4:0]      rs1D, rs2D, rdD;
   ctrl_t           ctrlD, ctrlE;
   imm_src_e        immSrcD;
   logic            useRs1, useRs2, useRd, legalD;
   logic [XLEN-1:0] rf1, rf2, immD;
   logic            loadUse, kill;

   assign opcode = InstrD[6:0];
   assign rdD    = InstrD[11:7];
   assign funct3 = InstrD[14:12];
   assign rs1D   = InstrD[19:15];
   assign rs2D   = InstrD[24:20];
   assign funct7 = InstrD[31:25];

   reg_file_bp #(.NREGS(NREGS), .XLEN(XLEN), .BYPASS_WB(BYPASS_WB)) rf (
      .clk(clk), .rst(rst), .a1(rs1D), .a2(rs2D), .rd1(rf1), .rd2(rf2),
      .we(RegWriteW), .wa(RdW), .wd(ResultW)
   );

   always_comb begin
      ctrlD   = '0;
      immSrcD = IMM_NONE;
      useRs1  = 1'b0;
      useRs2  = 1'b0;
      useRd   = 1'b0;
      legalD  = 1'b1;
      case (opcode)
         OP_R: begin
            {useRs1, useRs2, useRd, ctrlD.regWrite} = '1;
            case ({funct7, funct3})
               {7'b0000000, 3'b000}: ctrlD.aluControl = ALU_ADD;
               {7'b0100000, 3'b000}: ctrlD.aluControl = ALU_SUB;
               {7'b0000000, 3'b111}: ctrlD.aluControl = ALU_AND;
               {7'b0000000, 3'b110}: ctrlD.aluControl = ALU_OR;
               {7'b0000000, 3'b010}: ctrlD.aluControl = ALU_SLT;
               default:              legalD = 1'b0;
            endcase
         end
         OP_IALU: begin
            {useRs1, useRd, ctrlD.regWrite, ctrlD.aluSrc} = '1;
            immSrcD = IMM_I;
            case (funct3)
               3'b000:  ctrlD.aluControl = ALU_ADD;
               3'b010:  ctrlD.aluControl = ALU_SLT;
               3'b110:  ctrlD.aluControl = ALU_OR;
               3'b111:  ctrlD.aluControl = ALU_AND;
               default: legalD = 1'b0;
            endcase
         end
         OP_LW: begin
            {useRs1, useRd, ctrlD.regWrite, ctrlD.aluSrc} = '1;
            ctrlD.resultSrc = RES_MEM;
            immSrcD = IMM_I;
            legalD  = (funct3 == 3'b010);
         end
         OP_SW: begin
            {useRs1, useRs2, ctrlD.memWrite, ctrlD.aluSrc} = '1;
            immSrcD = IMM_S;
            legalD  = (funct3 == 3'b010);
         end
         OP_BEQ: begin
            {useRs1, useRs2, ctrlD.branch} = '1;
            ctrlD.aluControl = ALU_SUB;
            immSrcD = IMM_B;
            legalD  = (funct3 == 3'b000);
         end
         OP_JAL: begin
            {useRd, ctrlD.jump, ctrlD.regWrite} = '1;
            ctrlD.resultSrc = RES_PC4;
            immSrcD = IMM_J;
         end
         default: legalD = 1'b0;
      endcase
      if (NREGS < 32 && ((useRs1 && rs1D[4]) || (useRs2 && rs2D[4]) || (useRd && rdD[4])))
         legalD = 1'b0;
   end

   assign immD = XLEN'($signed(immExt32(InstrD, immSrcD)));

   // Only register fields the format actually reads can create a load-use hazard
   assign loadUse = (ctrlE.resultSrc == RES_MEM) && (RdE != '0) && legalD &&
                    ((useRs1 && RdE == rs1D) || (useRs2 && RdE == rs2D));
   assign StallD  = loadUse && !FlushE;
   assign kill    = FlushE || loadUse;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ctrlE    <= '0;
         RD1E     <= '0;
         RD2E     <= '0;
         PCE      <= '0;
         PCPlus4E <= '0;
         Rs1E     <= '0;
         Rs2E     <= '0;
         RdE      <= '0;
         ImmExtE  <= '0;
         IllegalE <= 1'b0;
      end else if (FlushE || !StallE) begin
         // Flush overrides the hold; a load-use hit only bubbles when E may advance
         ctrlE    <= (kill || !legalD)           ? '0 : ctrlD;
         RD1E     <= (kill || !legalD || !useRs1) ? '0 : rf1;
         RD2E     <= (kill || !legalD || !useRs2) ? '0 : rf2;
         PCE      <= (kill || !legalD)           ? '0 : PCD;
         PCPlus4E <= (kill || !legalD)           ? '0 : PCPlus4D;
         Rs1E     <= (kill || !legalD || !useRs1) ? '0 : rs1D;
         Rs2E     <= (kill || !legalD || !useRs2) ? '0 : rs2D;
         RdE      <= (kill || !legalD || !useRd)  ? '0 : rdD;
         ImmExtE  <= (kill || !legalD)           ? '0 : immD;
         IllegalE <= !kill && !legalD;
      end
   end

   assign RegWriteE   = ctrlE.regWrite;
   assign MemWriteE   = ctrlE.memWrite;
   assign JumpE       = ctrlE.jump;
   assign BranchE     = ctrlE.branch;
   assign ALUSrcE     = ctrlE.aluSrc;
   assign ResultSrcE  = ctrlE.resultSrc;
   assign ALUControlE = ctrlE.aluControl;

endmodule
